linear_output_stage: RTL and testbench

- Downstream of the vector multiplier generator. Consumes its MUL_PER_FEATURE partial sums (acc) and zero-point correction terms (ai) once per beat.
- Accumulates NUM_BEATS beats into one output neuron, adds bias, then requantizes: multiply, rounding right shift, zero point, optional ReLU, saturation.
- Emits one signed PRECISION-bit activation per neuron with a one-cycle valid pulse.

---
 rtl/linear_output_stage.sv | 171 +++++++++++++++++
 tb/tb_linear_output_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/linear_output_stage.sv
// linear_output_stage: reduces per-beat partial sums, accumulates NUM_BEATS beats
// into one neuron, adds bias, then requantizes (scale, rounding shift, zero point,
// optional ReLU, saturation) to a signed PRECISION-bit activation.
// Latency: out_valid pulses 4 cycles after the final beat is presented (ce high).
// No backpressure: ce=0 freezes every register; otherwise one beat per cycle.
// Ports: clk/rst (sync, active-low)/ce; in_valid + acc/ai lanes (flat, lane 0 in
// the low bits); quasi-static bias/requant_mult/requant_shift/out_zero_point/relu_en;
// out_valid/out_data result; busy while any beat or result is in flight.
module linear_output_stage #(
  parameter int MUL_PER_FEATURE = 4,
  parameter int PRECISION       = 8,
  parameter int BIAS_PRECISION  = 32,
  parameter int NUM_BEATS       = 4,
  parameter int MULT_WIDTH      = 32,
  parameter int SHIFT_WIDTH     = 6
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      ce,
  input  logic                                      in_valid,
  input  logic [MUL_PER_FEATURE*BIAS_PRECISION-1:0] acc,
  input  logic [MUL_PER_FEATURE*BIAS_PRECISION-1:0] ai,
  input  logic [BIAS_PRECISION-1:0]                 bias,
  input  logic [MULT_WIDTH-1:0]                     requant_mult,
  input  logic [SHIFT_WIDTH-1:0]                    requant_shift,
  input  logic [PRECISION-1:0]                      out_zero_point,
  input  logic                                      relu_en,
  output logic                                      out_valid,
  output logic [PRECISION-1:0]                      out_data,
  output logic                                      busy
);

  localparam int BP = BIAS_PRECISION;
  localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  // Full signed x unsigned product width.
  localparam int PW = BIAS_PRECISION + MULT_WIDTH + 1;
  // Two guard bits so rounding and zero-point addition never overflow.
  localparam int QW = PW + 2;
  localparam logic [CW-1:0] LAST = CW'(NUM_BEATS - 1);
  localparam logic signed [QW-1:0] SAT_MAX = {{(QW-PRECISION+1){1'b0}}, {(PRECISION-1){1'b1}}};
  localparam logic signed [QW-1:0] SAT_MIN = {{(QW-PRECISION+1){1'b1}}, {(PRECISION-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  // S1: lane reduction
  logic [BP-1:0] red;
  logic          s1_vld;
  logic [BP-1:0] s1_r;

  always_comb begin
    red = '0;
    for (int i = 0; i < MUL_PER_FEATURE; i++) begin
      red = red + acc[i*BP +: BP] - ai[i*BP +: BP];
    end
  end

  // S2: beat accumulation FSM
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BP-1:0] acc_reg, acc_nxt;
  logic          s2_vld, s2_vld_nxt;
  logic [BP-1:0] s2_sum, s2_sum_nxt;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    acc_nxt    = acc_reg;
    s2_vld_nxt = 1'b0;
    s2_sum_nxt = s2_sum;
    case (state)
      IDLE: begin
        if (s1_vld) begin
          if (NUM_BEATS == 1) begin
            s2_vld_nxt = 1'b1;
            s2_sum_nxt = s1_r + bias;
          end else begin
            acc_nxt   = s1_r;
            cnt_nxt   = CW'(1);
            state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (s1_vld) begin
          if (cnt == LAST) begin
            // Final beat: bias is taken from the current input, not earlier.
            s2_vld_nxt = 1'b1;
            s2_sum_nxt = acc_reg + s1_r + bias;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            acc_nxt = acc_reg + s1_r;
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // S3: signed sum times unsigned scale, exact
  logic signed [PW-1:0] sum_ext, mult_ext, prod;
  logic                 s3_vld;
  logic signed [PW-1:0] s3_p;

  always_comb begin
    sum_ext  = {{(PW-BP){s2_sum[BP-1]}}, s2_sum};
    mult_ext = {{(PW-MULT_WIDTH){1'b0}}, requant_mult};
    prod     = sum_ext * mult_ext;
  end

  // S4: round half up, zero point, ReLU, saturate
  logic signed [QW-1:0] p_ext, rnd, q_shift, zp_ext, q_zp;
  logic [PRECISION-1:0] sat_dat;

  always_comb begin
    p_ext  = {{(QW-PW){s3_p[PW-1]}}, s3_p};
    zp_ext = {{(QW-PRECISION){out_zero_point[PRECISION-1]}}, out_zero_point};
    rnd    = '0;
    if (requant_shift != '0) begin
      rnd = QW'(1) << (requant_shift - 1'b1);
    end
    q_shift = (p_ext + rnd) >>> requant_shift;
    q_zp    = q_shift + zp_ext;
    if (relu_en && (q_zp < zp_ext)) begin
      q_zp = zp_ext;
    end
    if (q_zp > SAT_MAX) begin
      sat_dat = {1'b0, {(PRECISION-1){1'b1}}};
    end else if (q_zp < SAT_MIN) begin
      sat_dat = {1'b1, {(PRECISION-1){1'b0}}};
    end else begin
      sat_dat = q_zp[PRECISION-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld    <= 1'b0;
      s1_r      <= '0;
      state     <= IDLE;
      cnt       <= '0;
      acc_reg   <= '0;
      s2_vld    <= 1'b0;
      s2_sum    <= '0;
      s3_vld    <= 1'b0;
      s3_p      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ce) begin
      s1_vld  <= in_valid;
      s1_r    <= red;
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc_reg <= acc_nxt;
      s2_vld  <= s2_vld_nxt;
      s2_sum  <= s2_sum_nxt;
      s3_vld  <= s2_vld;
      s3_p    <= prod;
      out_valid <= s3_vld;
      // out_data only moves on a new result so it holds between strobes.
      if (s3_vld) begin
        out_data <= sat_dat;
      end
    end
  end

  assign busy = (cnt != '0) | s1_vld | s2_vld | s3_vld;

endmodule

// File: tb/tb_linear_output_stage.sv
module tb_linear_output_stage;

  logic         clk = 1'b0;
  logic         rst, ce, iv1, iv2, relu;
  logic [127:0] acc_v, ai_v;
  logic [31:0]  bias, mult;
  logic [5:0]   shift;
  logic [7:0]   zp;
  logic         ov1, ov2, busy1, busy2;
  logic [7:0]   od1, od2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  linear_output_stage #(.NUM_BEATS(1)) u1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv1), .acc(acc_v), .ai(ai_v),
    .bias(bias), .requant_mult(mult), .requant_shift(shift),
    .out_zero_point(zp), .relu_en(relu),
    .out_valid(ov1), .out_data(od1), .busy(busy1)
  );

  linear_output_stage #(.NUM_BEATS(2)) u2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv2), .acc(acc_v), .ai(ai_v),
    .bias(bias), .requant_mult(mult), .requant_shift(shift),
    .out_zero_point(zp), .relu_en(relu),
    .out_valid(ov2), .out_data(od2), .busy(busy2)
  );

  typedef struct {
    int a0; int i0; int b; int m; int sh; int zpv; bit rl; int exp;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic int model(input longint s, input longint m, input int sh,
                               input int zpv, input bit rl);
    longint p, q;
    p = s * m;
    if (sh > 0) q = (p + (64'sd1 <<< (sh - 1))) >>> sh;
    else        q = p;
    q = q + zpv;
    if (rl && q < zpv) q = zpv;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic basic_params;
    bias = 32'd8; mult = 32'd32768; shift = 6'd16; zp = 8'd0; relu = 1'b0;
  endtask

  task automatic beat2;
    iv2 = 1'b1;
    acc_v = lanes(10, 20, 30, 40);
    ai_v  = lanes(1, 1, 1, 1);
    tick;
    iv2 = 1'b0;
  endtask

  vec_t vecs[11];

  initial begin
    rst = 1'b0; ce = 1'b1; iv1 = 1'b0; iv2 = 1'b0;
    acc_v = '0; ai_v = '0; bias = '0; mult = '0; shift = '0; zp = '0; relu = 1'b0;

    //            a0           i0  bias  mult   sh  zp  relu exp
    vecs[0]  = '{-50,          0,  0,    65536, 16, 3,   0, -47};
    vecs[1]  = '{-50,          0,  0,    65536, 16, 3,   1, 3};
    vecs[2]  = '{1000,         0,  0,    1,     0,  0,   0, 127};
    vecs[3]  = '{-1000,        0,  0,    1,     0,  0,   0, -128};
    vecs[4]  = '{3,            0,  0,    1,     1,  0,   0, 2};
    vecs[5]  = '{-3,           0,  0,    1,     1,  0,   0, -1};
    vecs[6]  = '{7,            2,  -1,   3,     2,  -5,  0, -2};
    vecs[7]  = '{-1,           0,  0,    1,     1,  0,   0, 0};
    vecs[8]  = '{20,           0,  0,    1,     0,  -10, 1, 10};
    vecs[9]  = '{0,            0,  -300, 1,     0,  0,   1, 0};
    vecs[10] = '{2147483647,   -1, 0,    1,     24, 0,   0, -128};

    tick; tick;
    chk("rst_out_valid1", int'(ov1), 0);
    chk("rst_out_data1", int'($signed(od1)), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_out_valid2", int'(ov2), 0);
    chk("rst_out_data2", int'($signed(od2)), 0);
    chk("rst_busy2", int'(busy2), 0);
    rst = 1'b1;
    tick;

    // Single-beat requantization vectors on the NUM_BEATS=1 instance.
    for (int v = 0; v < 11; v++) begin
      bias = vecs[v].b; mult = vecs[v].m; shift = 6'(vecs[v].sh);
      zp = 8'(vecs[v].zpv); relu = vecs[v].rl;
      acc_v = lanes(vecs[v].a0, 0, 0, 0);
      ai_v  = lanes(0, vecs[v].i0, 0, 0);
      iv1 = 1'b1;
      tick;
      iv1 = 1'b0;
      tick; tick;
      chk($sformatf("vec%0d_early", v), int'(ov1), 0);
      tick;
      chk($sformatf("vec%0d_valid", v), int'(ov1), 1);
      chk($sformatf("vec%0d_data", v), int'($signed(od1)), vecs[v].exp);
      tick;
      chk($sformatf("vec%0d_pulse", v), int'(ov1), 0);
    end

    // Basic two-beat neuron.
    basic_params;
    beat2;
    beat2;
    tick;
    chk("basic_e1", int'(ov2), 0);
    tick;
    chk("basic_e2", int'(ov2), 0);
    tick;
    chk("basic_valid", int'(ov2), 1);
    chk("basic_data", int'($signed(od2)), 100);
    tick;
    chk("basic_pulse", int'(ov2), 0);
    chk("basic_hold", int'($signed(od2)), 100);
    chk("basic_idle_busy", int'(busy2), 0);

    // Gaps between beats, then a 3-cycle stall with the result in S3.
    beat2;
    tick; tick; tick;
    chk("gap_busy", int'(busy2), 1);
    beat2;
    tick; tick;
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("stall_hold%0d", i), int'(ov2), 0);
    end
    chk("stall_busy", int'(busy2), 1);
    ce = 1'b1;
    tick;
    chk("stall_valid", int'(ov2), 1);
    chk("stall_data", int'($signed(od2)), 100);
    ce = 1'b0;
    tick;
    chk("ce_hold_valid", int'(ov2), 1);
    ce = 1'b1;
    tick;
    chk("stall_pulse", int'(ov2), 0);

    // Reset mid-neuron discards the first beat.
    iv2 = 1'b1;
    acc_v = lanes(100, 0, 0, 0);
    ai_v  = lanes(4, 0, 0, 0);
    tick;
    iv2 = 1'b0;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("rstmid_busy", int'(busy2), 0);
    chk("rstmid_valid", int'(ov2), 0);
    beat2;
    chk("rstmid_nostray", int'(ov2), 0);
    beat2;
    tick; tick;
    chk("rstmid_early", int'(ov2), 0);
    tick;
    chk("rstmid_out_valid", int'(ov2), 1);
    chk("rstmid_data", int'($signed(od2)), 100);
    tick;

    // Eight back-to-back neurons, in_valid held high.
    begin
      int expq[8];
      int pulses;
      int last;
      pulses = 0;
      last = -1;
      for (int n = 0; n < 8; n++) begin
        expq[n] = model(longint'((n*37 - 150 - n) + (n*37 - 150 + 5 - n) + 8),
                        32768, 16, 0, 1'b0);
      end
      for (int t = 0; t < 24; t++) begin
        if (t < 16) begin
          iv2 = 1'b1;
          acc_v = lanes((t/2)*37 - 150 + (t%2)*5, 0, 0, 0);
          ai_v  = lanes(0, t/2, 0, 0);
        end else begin
          iv2 = 1'b0;
        end
        tick;
        if (ov2) begin
          if (pulses < 8) chk($sformatf("tput_data%0d", pulses), int'($signed(od2)), expq[pulses]);
          if (pulses == 0) chk("tput_first", t, 4);
          else             chk("tput_gap", t - last, 2);
          last = t;
          pulses++;
        end
      end
      chk("tput_count", pulses, 8);
      chk("tput_busy_end", int'(busy2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
